// File: rtl/bit_window_sequencer.sv
// Paced sliding-window reader for a 1-bit block memory.
// Shares the memory port with a debug reader; the stream always wins.
module bit_window_sequencer #(
   parameter int ADDR_W   = 14,
   parameter int WIN      = 4,
   parameter int TICK_DIV = 100000000
) (
   input  logic              clock_100Mhz,
   input  logic              reset,
   input  logic              start,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_dout,
   output logic              bit_valid,
   output logic              bit_data,
   output logic              bit_first,
   output logic              bit_last,
   output logic [ADDR_W-1:0] window_base,
   input  logic              dbg_req,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic              dbg_ack,
   output logic              dbg_data,
   output logic              busy,
   output logic              done
);

   localparam int CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] TICK_MAX = CW'(TICK_DIV - 1);
   localparam logic [ADDR_W-1:0] OFF_LAST = ADDR_W'(WIN - 1);
   localparam logic [ADDR_W-1:0] BASE_LAST = ADDR_W'((1 << ADDR_W) - WIN);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WAIT  = 3'd1;
   localparam logic [2:0] S_ISSUE = 3'd2;
   localparam logic [2:0] S_CAPT  = 3'd3;
   localparam logic [2:0] S_OUT   = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] off_q, off_d;
   logic [CW-1:0]     tick_q, tick_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              bv_q, bv_d;
   logic              bd_q, bd_d;
   logic              bf_q, bf_d;
   logic              bl_q, bl_d;
   logic              dpend_q, dpend_d;
   logic              dcap_q, dcap_d;
   logic              darm_q, darm_d;
   logic              dack_q, dack_d;
   logic              ddat_q, ddat_d;
   logic              tick;
   logic              grant;

   assign tick  = (tick_q == TICK_MAX);
   assign grant = dpend_q && (state_q != S_ISSUE);

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      off_d   = off_q;
      busy_d  = busy_q;
      done_d  = done_q;
      bv_d    = 1'b0;
      bd_d    = bd_q;
      bf_d    = bf_q;
      bl_d    = bl_q;
      tick_d  = '0;
      if (busy_q) begin
         tick_d = tick ? '0 : tick_q + CW'(1);
      end
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_WAIT;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               base_d  = '0;
               off_d   = '0;
               tick_d  = '0;
            end
         end
         S_WAIT: begin
            if (tick) begin
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: state_d = S_CAPT;
         S_CAPT: begin
            // strobe is registered here so it lands in the OUT cycle
            state_d = S_OUT;
            bv_d    = 1'b1;
            bd_d    = mem_dout;
            bf_d    = (off_q == '0);
            bl_d    = (off_q == OFF_LAST);
            if (off_q == OFF_LAST && base_q == BASE_LAST) begin
               busy_d = 1'b0;
               done_d = 1'b1;
            end
         end
         S_OUT: begin
            if (off_q != OFF_LAST) begin
               off_d   = off_q + ADDR_W'(1);
               state_d = S_WAIT;
            end else if (base_q == BASE_LAST) begin
               state_d = S_IDLE;
            end else begin
               base_d  = base_q + ADDR_W'(1);
               off_d   = '0;
               state_d = S_WAIT;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      dpend_d = dpend_q;
      darm_d  = darm_q;
      dack_d  = 1'b0;
      ddat_d  = ddat_q;
      dcap_d  = grant;
      if (!dbg_req) begin
         darm_d = 1'b1;
      end
      // a new request needs dbg_req seen low since the last acceptance
      if (dbg_req && darm_q && !dpend_q && !dcap_q) begin
         dpend_d = 1'b1;
         darm_d  = 1'b0;
      end
      if (grant) begin
         dpend_d = 1'b0;
      end
      if (dcap_q) begin
         dack_d = 1'b1;
         ddat_d = mem_dout;
      end
   end

   always_comb begin
      mem_en   = 1'b0;
      mem_addr = '0;
      if (state_q == S_ISSUE) begin
         mem_en   = 1'b1;
         mem_addr = base_q + off_q;
      end else if (dpend_q) begin
         mem_en   = 1'b1;
         mem_addr = dbg_addr;
      end
   end

   always_ff @(posedge clock_100Mhz or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         base_q  <= '0;
         off_q   <= '0;
         tick_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         bv_q    <= 1'b0;
         bd_q    <= 1'b0;
         bf_q    <= 1'b0;
         bl_q    <= 1'b0;
         dpend_q <= 1'b0;
         dcap_q  <= 1'b0;
         darm_q  <= 1'b1;
         dack_q  <= 1'b0;
         ddat_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         off_q   <= off_d;
         tick_q  <= tick_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         bv_q    <= bv_d;
         bd_q    <= bd_d;
         bf_q    <= bf_d;
         bl_q    <= bl_d;
         dpend_q <= dpend_d;
         dcap_q  <= dcap_d;
         darm_q  <= darm_d;
         dack_q  <= dack_d;
         ddat_q  <= ddat_d;
      end
   end

   assign bit_valid   = bv_q;
   assign bit_data    = bd_q;
   assign bit_first   = bf_q;
   assign bit_last    = bl_q;
   assign window_base = base_q;
   assign dbg_ack     = dack_q;
   assign dbg_data    = ddat_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule
